// File: rtl/otter_pkg.sv
// Shared OTTER constants and types.
// Load funct3 codes and write-back buffer parameters.
package otter_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam int         WB_FIFO_DEPTH   = 4;
  localparam logic [2:0] WB_STARVE_LIMIT = 3'd7;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/otter_ld_align.sv
// Load return alignment and extension.
// Selects byte/halfword by address offset and extends per funct3.
module otter_ld_align
  import otter_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = data[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? data[31:16] : data[15:0];
    result   = data;
    unique case (1'b1)
      (funct3 == LB):  result = {{24{byte_sel[7]}}, byte_sel};
      (funct3 == LBU): result = {24'd0, byte_sel};
      (funct3 == LH):  result = {{16{half_sel[15]}}, half_sel};
      (funct3 == LHU): result = {16'd0, half_sel};
      default:         result = data;
    endcase
  end

endmodule

// File: rtl/otter_wb_arbiter.sv
// Register-file write-back arbiter: pipeline results vs buffered loads.
// Loads queue in a 4-deep FIFO; a starvation counter forces a drain.
module otter_wb_arbiter
  import otter_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pipe_valid,
  input  logic [4:0]  i_pipe_rd,
  input  logic [31:0] i_pipe_data,
  input  logic        i_ld_valid,
  output logic        o_ld_ready,
  input  logic [4:0]  i_ld_rd,
  input  logic [31:0] i_ld_data,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_addr_lo,
  output logic        o_w_en,
  output logic [4:0]  o_w_addr,
  output logic [31:0] o_w_data,
  output logic [31:0] o_pend_mask,
  output logic        o_stall
);

  localparam logic [2:0] DEPTH = 3'(WB_FIFO_DEPTH);

  wb_entry_t   fifo [WB_FIFO_DEPTH];
  logic [1:0]  wptr;
  logic [1:0]  rptr;
  logic [2:0]  count;
  logic [2:0]  starve;
  logic [31:0] ld_ext;
  logic [31:0] mask;
  logic        nonempty;
  logic        push;
  logic        pop;
  logic        take_pipe;

  otter_ld_align u_align (
    .data    (i_ld_data),
    .funct3  (i_ld_funct3),
    .addr_lo (i_ld_addr_lo),
    .result  (ld_ext)
  );

  assign nonempty   = (count != 3'd0);
  assign o_ld_ready = (count < DEPTH);
  assign o_stall    = (starve == WB_STARVE_LIMIT);
  assign push = i_ld_valid && o_ld_ready
             && (i_ld_rd != 5'd0);

  // Forced drain outranks the pipeline; rd=0 pipe writes never block.
  always_comb begin
    pop       = 1'b0;
    take_pipe = 1'b0;
    if (o_stall && nonempty) begin
      pop = 1'b1;
    end else if (i_pipe_valid
                 && (i_pipe_rd != 5'd0)) begin
      take_pipe = 1'b1;
    end else if (nonempty) begin
      pop = 1'b1;
    end
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
      if (3'(i) < count)
        mask[fifo[rptr + 2'(i)].rd] = 1'b1;
    end
    o_pend_mask = mask & ~32'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < WB_FIFO_DEPTH; i++)
        fifo[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        fifo[wptr] <= '{rd: i_ld_rd, data: ld_ext};
        wptr       <= wptr + 2'd1;
      end
      if (pop)
        rptr <= rptr + 2'd1;
      count <= count + 3'(push) - 3'(pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      starve <= '0;
    else if (!nonempty || pop)
      starve <= '0;
    else if (!o_stall)
      starve <= starve + 3'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_w_en   <= 1'b0;
      o_w_addr <= '0;
      o_w_data <= '0;
    end else if (pop) begin
      o_w_en   <= 1'b1;
      o_w_addr <= fifo[rptr].rd;
      o_w_data <= fifo[rptr].data;
    end else if (take_pipe) begin
      o_w_en   <= 1'b1;
      o_w_addr <= i_pipe_rd;
      o_w_data <= i_pipe_data;
    end else begin
      o_w_en   <= 1'b0;
    end
  end

endmodule

// File: doc/otter_wb_arbiter.md
OTTER_WB_ARBITER -- requirements
Module: otter_wb_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 i_clk  in  1  rising-edge clock.
REQ-003 i_rst_n  in  1  asynchronous active-low reset.
REQ-004 i_pipe_valid  in  1  pipeline ALU/CSR/JAL result is present this cycle; it has no backpressure.
REQ-005 i_pipe_rd  in  5  pipeline destination register.
REQ-006 i_pipe_data  in  32  pipeline result.
REQ-007 i_ld_valid  in  1  a memory load return is offered.
REQ-008 o_ld_ready  out  1  the load return is accepted when both valid and ready are high at a rising edge.
REQ-009 i_ld_rd  in  5  load destination register.
REQ-010 i_ld_data  in  32  raw aligned memory word.
REQ-011 i_ld_funct3  in  3  load type.
REQ-012 i_ld_addr_lo  in  2  byte offset of the load address.
REQ-013 o_w_en, o_w_addr[5], o_w_data[32]  out  register-file write port; connects to i_w_en/i_w_addr/i_w_data of otter_rfile.
REQ-014 o_pend_mask  out  32  bit r is set while any buffered load targets register r.
REQ-015 o_stall  out  1  drain request; the pipeline SHALL hold i_pipe_valid low in any cycle where o_stall is high.

Function
REQ-016 Load returns SHALL be buffered in a 4-entry FIFO of {rd, extended data}.
REQ-017 o_ld_ready SHALL equal (count < 4), decoded from registered state only, with no combinational path from i_ld_valid or i_pipe_valid.
REQ-018 An accepted load with i_ld_rd=0 SHALL be discarded and not pushed.
REQ-019 Load extension SHALL be applied at push time:
- LB 000 / LBU 100: byte i_ld_addr_lo, sign- or zero-extended.
- LH 001 / LHU 101: halfword i_ld_addr_lo[1], sign- or zero-extended.
- LW 010 and all other codes: raw word.
REQ-020 Write slot selection at each rising edge SHALL follow this priority:
- o_stall=1 and FIFO non-empty: pop the head.
- else i_pipe_valid=1 and i_pipe_rd!=0: take the pipeline write.
- else FIFO non-empty: pop the head.
- else no write.
REQ-021 A pipeline write with rd=0 SHALL be dropped and SHALL NOT block a FIFO drain.
REQ-022 o_w_en/o_w_addr/o_w_data SHALL be registered. Pipeline-to-write latency SHALL be 1 edge; load accept-to-write latency SHALL be at least 2 edges.
REQ-023 o_w_en SHALL be 0 in any cycle with no selected write; o_w_addr/o_w_data SHALL hold their last values.
REQ-024 A popped entry SHALL always have rd!=0, so o_w_addr is never 0 while o_w_en is 1.
REQ-025 A simultaneous push and pop SHALL leave count unchanged; the pointers SHALL wrap modulo 4.
REQ-026 A 3-bit starvation counter SHALL behave as follows:
- It increments each edge the FIFO is non-empty and no pop occurs.
- It clears on any pop or when the FIFO is empty.
- It saturates at 7.
REQ-027 o_stall SHALL be high exactly while the starvation counter equals 7.
REQ-028 o_pend_mask SHALL be the OR of one-hot(rd) over valid FIFO entries, from registered state; bit 0 SHALL always be 0.
REQ-029 A popped entry's bit SHALL clear on the same edge that loads o_w_en, so the register file holds the value before the hazard releases.
REQ-030 Loads SHALL be written in acceptance order.

Reset
REQ-031 Asserting i_rst_n low SHALL immediately set the following, regardless of the clock:
- o_w_en=0, o_w_addr=0, o_w_data=0;
- FIFO empty (count=0, pointers=0);
- starvation counter=0, so o_stall=0;
- o_pend_mask=0 and o_ld_ready=1.
REQ-032 Reset asserted mid-operation SHALL discard all buffered loads; no write SHALL issue on the first edge after release.

Structure
REQ-033 The shared package otter_pkg SHALL hold:
- the load funct3 constants LB, LH, LW, LBU, LHU;
- WB_FIFO_DEPTH=4 and WB_STARVE_LIMIT=7;
- typedef wb_entry_t {rd[5], data[32]}.
REQ-034 Load extension SHALL be a combinational sub-module otter_ld_align (inputs: data, funct3, addr_lo; output: 32-bit result).
REQ-035 The FIFO, the arbitration logic and the output register SHALL be inline in otter_wb_arbiter.

Verification
REQ-036 The bench SHALL cover these directed scenarios:
- Pipe write rd=5, data=0x12345678 -> o_w_en=1, addr=5, data=0x12345678 one edge later.
- Loads LB addr_lo=3 word 0x80FF_0000 rd=7, then LHU addr_lo=2 word 0xBEEF_1234 rd=8, pipe idle -> writes 0xFFFF_FF80 to x7, then 0x0000_BEEF to x8, in order.
- Five back-to-back loads with pipe continuously valid (rd=1) -> o_ld_ready low after 4 accepts; o_pend_mask shows all 4 rd bits.
- Continue the previous scenario -> o_stall rises after 7 starved edges; head drains in that cycle; o_stall falls.
- Load rd=0 and pipe rd=0 in the same cycle -> no write; FIFO count stays 0.
- Reset with 3 entries buffered -> outputs 0, o_pend_mask=0, o_ld_ready=1; no stale write after release.
- Attach otter_rfile to the write port -> every write above is read back correctly via o_r_rs1.
